// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential signed add/sub/mul/rem unit with result flags
// add/sub finish on accept; mul and rem iterate one magnitude bit per cycle.
module seq_alu #(
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] r,
  output logic           sf,
  output logic           zf,
  output logic           dzf
);

  localparam int CW = $clog2(W + 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_REM = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [1:0]      r_op;
  logic            r_neg;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_acc;
  logic [2*W-1:0]  r_mc;
  logic [W:0]      r_mp;
  logic [W:0]      r_rem;
  logic [W-1:0]    r_dvd;
  logic [W:0]      r_dvs;
  logic            r_busy;
  logic            r_done;
  logic [2*W-1:0]  r_r;
  logic            r_sf;
  logic            r_zf;
  logic            r_dzf;

  logic            w_accept;
  logic            w_last;
  logic [W:0]      w_a_ext;
  logic [W:0]      w_b_ext;
  logic [W:0]      w_mag_a;
  logic [W:0]      w_mag_b;
  logic [2*W-1:0]  w_a_sx;
  logic [2*W-1:0]  w_b_sx;
  logic [2*W-1:0]  w_acc_next;
  logic [W:0]      w_rsh;
  logic [W:0]      w_rem_next;
  logic [2*W-1:0]  w_rem_ext;
  logic [2*W-1:0]  w_run_res;
  logic            w_load;
  logic [2*W-1:0]  w_load_val;
  logic            w_load_dz;

  always_comb begin
    w_accept   = start && (r_state != RUN);
    w_last     = (r_cnt == CW'(W - 1));
    // W+1-bit magnitudes so that -2^(W-1) has a representable absolute value
    w_a_ext    = {a[W-1], a};
    w_b_ext    = {b[W-1], b};
    w_mag_a    = a[W-1] ? -w_a_ext : w_a_ext;
    w_mag_b    = b[W-1] ? -w_b_ext : w_b_ext;
    w_a_sx     = {{W{a[W-1]}}, a};
    w_b_sx     = {{W{b[W-1]}}, b};
    w_acc_next = r_acc + (r_mp[0] ? r_mc : '0);
    w_rsh      = {r_rem[W-1:0], r_dvd[W-1]};
    w_rem_next = (w_rsh >= r_dvs) ? (w_rsh - r_dvs) : w_rsh;
    w_rem_ext  = {{(W-1){1'b0}}, w_rem_next};
    if (r_op == OP_MUL) begin
      w_run_res = r_neg ? -w_acc_next : w_acc_next;
    end else begin
      w_run_res = r_neg ? -w_rem_ext : w_rem_ext;
    end

    w_load     = 1'b0;
    w_load_val = '0;
    w_load_dz  = 1'b0;
    if (r_state == RUN) begin
      w_load     = w_last;
      w_load_val = w_run_res;
    end else if (w_accept) begin
      w_load     = (op == OP_ADD) || (op == OP_SUB) || ((op == OP_REM) && (b == '0));
      w_load_val = (op == OP_ADD) ? (w_a_sx + w_b_sx) :
                   (op == OP_SUB) ? (w_a_sx - w_b_sx) : '0;
      w_load_dz  = (op == OP_REM);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mc    <= '0;
      r_mp    <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_r     <= '0;
      r_sf    <= 1'b0;
      r_zf    <= 1'b0;
      r_dzf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_r   <= w_load_val;
        r_sf  <= w_load_val[2*W-1];
        r_zf  <= (w_load_val == '0);
        r_dzf <= w_load_dz;
      end
      case (r_state)
        RUN: begin
          r_acc <= w_acc_next;
          r_mc  <= r_mc << 1;
          r_mp  <= r_mp >> 1;
          r_rem <= w_rem_next;
          r_dvd <= r_dvd << 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          if (w_accept) begin
            r_op  <= op;
            r_cnt <= '0;
            r_acc <= '0;
            r_rem <= '0;
            r_mc  <= {{(W-1){1'b0}}, w_mag_a};
            r_mp  <= w_mag_b;
            r_dvd <= w_mag_a[W-1:0];
            r_dvs <= w_mag_b;
            // product sign is the xor of operand signs; remainder sign follows a
            r_neg <= (op == OP_MUL) ? (a[W-1] ^ b[W-1]) : a[W-1];
            if ((op == OP_MUL) || ((op == OP_REM) && (b != '0))) begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign r    = r_r;
  assign sf   = r_sf;
  assign zf   = r_zf;
  assign dzf  = r_dzf;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu (W=3)
// Directed vector table, corner sequences and randomized ops against an integer model.
module tb_seq_alu;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] r;
  logic           sf;
  logic           zf;
  logic           dzf;

  int n_checks = 0;
  int n_pass   = 0;

  seq_alu #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .r(r), .sf(sf), .zf(zf), .dzf(dzf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [5:0] r;
    int         lat;
    logic       dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [5:0] model_r(input logic [1:0] o, input logic [2:0] x, input logic [2:0] y);
    int sa;
    int sb;
    int v;
    sa = $signed(x);
    sb = $signed(y);
    case (o)
      2'd0:    v = sa + sb;
      2'd1:    v = sa - sb;
      2'd2:    v = sa * sb;
      default: v = (sb == 0) ? 0 : sa % sb;
    endcase
    return v[5:0];
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [2:0] y);
    return ((o == 2'd2) || (o == 2'd3 && y != 3'd0)) ? W + 1 : 1;
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or on timeout).
  task automatic do_op(input logic [1:0] o, input logic [2:0] x, input logic [2:0] y,
                       output int lat, output int busy_n);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!done && lat < 30) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic check_res(input string nm, input logic [5:0] er, input int elat, input logic edz,
                           input int lat, input int busy_n);
    chk({nm, " latency"}, lat, elat);
    chk({nm, " busy cycles"}, busy_n, elat - 1);
    chk({nm, " r"}, r, er);
    chk({nm, " sf"}, sf, er[5]);
    chk({nm, " zf"}, zf, (er == 6'd0));
    chk({nm, " dzf"}, dzf, edz);
    chk({nm, " busy at done"}, busy, 1'b0);
  endtask

  initial begin
    int lat;
    int busy_n;
    int dcount;
    logic [1:0] o;
    logic [2:0] x;
    logic [2:0] y;

    vecs[0]  = '{2'd0, 3'b011, 3'b010, 6'b000101, 1, 1'b0};
    vecs[1]  = '{2'd1, 3'b001, 3'b011, 6'b111110, 1, 1'b0};
    vecs[2]  = '{2'd1, 3'b100, 3'b100, 6'b000000, 1, 1'b0};
    vecs[3]  = '{2'd2, 3'b101, 3'b011, 6'b110111, 4, 1'b0};
    vecs[4]  = '{2'd2, 3'b100, 3'b100, 6'b010000, 4, 1'b0};
    vecs[5]  = '{2'd3, 3'b101, 3'b010, 6'b111111, 4, 1'b0};
    vecs[6]  = '{2'd3, 3'b011, 3'b000, 6'b000000, 1, 1'b1};
    vecs[7]  = '{2'd3, 3'b100, 3'b111, 6'b000000, 4, 1'b0};
    vecs[8]  = '{2'd2, 3'b011, 3'b100, 6'b110100, 4, 1'b0};
    vecs[9]  = '{2'd3, 3'b011, 3'b110, 6'b000001, 4, 1'b0};
    vecs[10] = '{2'd0, 3'b100, 3'b100, 6'b111000, 1, 1'b0};
    vecs[11] = '{2'd2, 3'b111, 3'b111, 6'b000001, 4, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {busy, done, r, sf, zf, dzf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_n);
      check_res($sformatf("vec%0d", i), vecs[i].r, vecs[i].lat, vecs[i].dz, lat, busy_n);
      @(negedge clk);
    end

    // start pulses during busy are dropped; result holds while a new op runs
    start = 1'b1; op = 2'd2; a = 3'b101; b = 3'b011;
    @(negedge clk);
    op = 2'd0; a = 3'b001; b = 3'b001;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ignored start done", done, 1'b1);
    chk("ignored start r", r, 6'b110111);
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("ignored start no extra done", dcount, 0);
    start = 1'b1; op = 2'd2; a = 3'b011; b = 3'b011;
    @(negedge clk);
    start = 1'b0;
    chk("r held while busy", r, 6'b110111);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mul 3*3 after hold", r, 6'd9);

    // back-to-back: add issued in the mul's done cycle
    @(negedge clk);
    do_op(2'd2, 3'b010, 3'b011, lat, busy_n);
    check_res("b2b mul", 6'd6, 4, 1'b0, lat, busy_n);
    do_op(2'd0, 3'b001, 3'b001, lat, busy_n);
    check_res("b2b add", 6'd2, 1, 1'b0, lat, busy_n);

    // reset in cycle 2 of a mul, with a start request held during reset
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 3'b011; b = 3'b101;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1; op = 2'd0; a = 3'b001; b = 3'b001;
    @(negedge clk);
    chk("mid reset outputs", {busy, done, r, sf, zf, dzf}, 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("no done after reset", dcount, 0);

    for (int i = 0; i < 150; i++) begin
      o = 2'($urandom_range(0, 3));
      x = 3'($urandom);
      y = 3'($urandom);
      if ($urandom_range(0, 3) == 0) y = 3'd0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(o, x, y, lat, busy_n);
      check_res($sformatf("rand%0d op%0d a%0d b%0d", i, o, x, y), model_r(o, x, y),
                model_lat(o, y), (o == 2'd3 && y == 3'd0), lat, busy_n);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
